// File: rtl/systolic_x_feeder.sv
// systolic_x_feeder: buffers an M x N activation matrix and streams it diagonally skewed onto the array's X bus
module systolic_x_feeder #(
    parameter int M = 5,
    parameter int N = 3,
    parameter int DATA_WIDTH = 32,
    localparam int AW = (M > 1) ? $clog2(M) : 1,
    localparam int TW = $clog2(M + N),
    localparam int W = DATA_WIDTH * N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  x_out
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam logic [TW-1:0] LAST = TW'(M + N - 2);
    state_t        r_state;
    logic [TW-1:0] r_t;
    logic [W-1:0]  r_buf [M];
    logic [W-1:0]  r_x;
    logic          r_busy;
    logic          r_done;
    logic          w_wr;
    logic [TW-1:0] w_t;
    logic [W-1:0]  w_buf [M];
    logic [W-1:0]  w_beat;
    assign w_wr = wr_en && r_state == IDLE;
    assign w_t = (r_state == IDLE) ? '0 : r_t + 1'b1;
    // Same-edge write is folded in so beat(0) sees a row written together with start
    always_comb begin
        for (int r = 0; r < M; r++)
            w_buf[r] = (w_wr && wr_addr == AW'(r)) ? wr_data : r_buf[r];
    end
    always_comb begin
        w_beat = '0;
        for (int r = 0; r < M; r++)
            for (int i = 0; i < N; i++)
                if (int'(w_t) == r + i)
                    w_beat[i*DATA_WIDTH +: DATA_WIDTH] = w_buf[r][i*DATA_WIDTH +: DATA_WIDTH];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_buf   <= '{default: '0};
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_buf <= w_buf;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= STREAM;
                    r_t     <= '0;
                    r_x     <= w_beat;
                    r_busy  <= 1'b1;
                end
                STREAM: if (r_t == LAST) begin
                    r_state <= DONE;
                    r_x     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_t <= w_t;
                    r_x <= w_beat;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy  = r_busy;
    assign done  = r_done;
    assign x_out = r_x;
endmodule

// File: tb/tb_systolic_x_feeder.sv
// tb_systolic_x_feeder: randomized and directed checks of systolic_x_feeder against a matrix model
module tb_systolic_x_feeder;
    localparam int M = 5;
    localparam int N = 3;
    localparam int DW = 32;
    localparam int W = DW * N;
    localparam int L = M + N - 1;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] x_out;
    logic [DW-1:0] xm [M][N];
    logic [W-1:0]  tab [L];
    int n_chk = 0;
    int n_err = 0;

    systolic_x_feeder #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .x_out(x_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] row(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [W-1:0] beat(input int t);
        logic [W-1:0] b = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < M) b[i*DW +: DW] = xm[t-i][i];
        return b;
    endfunction

    task automatic set_model(input int a, input logic [W-1:0] d);
        if (a < M)
            for (int c = 0; c < N; c++) xm[a][c] = d[c*DW +: DW];
    endtask

    task automatic clear_model();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) xm[r][c] = '0;
    endtask

    task automatic write_row(input int a, input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        set_model(a, d);
    endtask

    task automatic load_ramp();
        for (int r = 0; r < M; r++)
            write_row(r, row(DW'(10*r+1), DW'(10*r+2), DW'(10*r+3)));
    endtask

    // Called at a falling edge with the DUT idle; checks every beat, the done pulse and the return to idle
    task automatic run_stream(input bit noise, input bit ws, input int a, input logic [W-1:0] d, input bit use_tab);
        start = 1'b1;
        if (ws) begin
            wr_en = 1'b1;
            wr_addr = 3'(a);
            wr_data = d;
            set_model(a, d);
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int t = 0; t < L; t++) begin
            check($sformatf("busy t%0d", t), W'(busy), W'(1));
            check($sformatf("done t%0d", t), W'(done), W'(0));
            check($sformatf("beat t%0d", t), x_out, beat(t));
            if (use_tab) check($sformatf("table t%0d", t), x_out, tab[t]);
            if (noise) begin
                wr_en = (t == 1);
                wr_addr = '0;
                wr_data = row(99, 99, 99);
                start = (t == 3);
            end
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
        end
        check("end busy", W'(busy), W'(0));
        check("end done", W'(done), W'(1));
        check("end x_out", x_out, '0);
        start = noise;
        @(negedge clk);
        start = 1'b0;
        check("post done", W'(done), W'(0));
        check("post busy", W'(busy), W'(0));
        check("post x_out", x_out, '0);
        @(negedge clk);
        check("idle busy", W'(busy), W'(0));
        check("idle done", W'(done), W'(0));
    endtask

    initial begin
        clear_model();
        for (int t = 0; t < L; t++) tab[t] = '0;
        tab[0] = row(1, 0, 0);   tab[1] = row(11, 2, 0);  tab[2] = row(21, 12, 3);
        tab[3] = row(31, 22, 13); tab[4] = row(41, 32, 23); tab[5] = row(0, 42, 33);
        tab[6] = row(0, 0, 43);
        @(negedge clk);
        check("rst x_out", x_out, '0);
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        rst = 1'b0;
        @(negedge clk);
        run_stream(0, 0, 0, '0, 0);
        load_ramp();
        run_stream(0, 0, 0, '0, 1);
        run_stream(1, 0, 0, '0, 1);
        run_stream(0, 0, 0, '0, 1);
        run_stream(0, 1, 4, row(7, 8, 9), 0);
        check("ws beat4 lane0", W'(xm[4][0]), W'(7));
        load_ramp();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-rst beat2", x_out, row(21, 12, 3));
        #2 rst = 1'b1;
        #1;
        check("async x_out", x_out, '0);
        check("async busy", W'(busy), W'(0));
        check("async done", W'(done), W'(0));
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("after rst done", W'(done), W'(0));
            check("after rst busy", W'(busy), W'(0));
            @(negedge clk);
        end
        run_stream(0, 0, 0, '0, 0);
        load_ramp();
        run_stream(0, 0, 0, '0, 1);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 6; j++)
                write_row($urandom_range(0, 7), {$urandom, $urandom, $urandom});
            run_stream($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                       {$urandom, $urandom, $urandom}, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
